// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: load modes, FSM states
// and the per-mode transfer byte count.
package mem_lsu_pkg;

    localparam logic [1:0] LD_WORD    = 2'b00;
    localparam logic [1:0] LD_HALF_S  = 2'b01;
    localparam logic [1:0] LD_HALF_U  = 2'b10;
    localparam logic [1:0] LD_ILLEGAL = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_XFER = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    function automatic logic [2:0] byte_count(input logic [1:0] mode);
        logic [2:0] n;
        case (mode)
            LD_WORD: n = 3'd4;
            default: n = 3'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lsu_extend.sv
// Turns the big-endian assembled load bytes into the architectural result:
// word as is, halfwords sign- or zero-extended from the low 16 bits.
module mem_lsu_extend
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_assembled,
    input  logic [1:0]  i_mode,
    output logic [31:0] o_data
);

    // Extension select; the illegal mode never reaches a successful load.
    always_comb begin
        o_data = i_assembled;
        case (i_mode)
            LD_WORD:   o_data = i_assembled;
            LD_HALF_S: o_data = {{16{i_assembled[15]}}, i_assembled[15:0]};
            LD_HALF_U: o_data = {16'h0000, i_assembled[15:0]};
            default:   o_data = i_assembled;
        endcase
    end

endmodule

// File: rtl/mem_load_store_unit.sv
// MEM-stage initiator: serialises one load/store into byte transfers on a
// big-endian valid/ack bus, with per-byte ack timeout and load extension.
module mem_load_store_unit
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  load_mode,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] bus_addr,
    output logic        bus_re,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] read_data,
    output logic        stall
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(ACK_TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic             r_is_load;
    logic [2:0]       r_k;
    logic [2:0]       r_last;
    logic [TMO_W-1:0] r_tmo;
    logic [31:0]      r_wsh;
    logic [23:0]      r_rsh;

    logic             w_accept;
    logic             w_err;
    logic             w_ack;
    logic [2:0]       w_last;
    logic [31:0]      w_st_data;
    logic [31:0]      w_assembled;
    logic [31:0]      w_ext;

    assign stall = !req_ready || (req_valid && req_ready);

    // Request decode; store data is left-aligned so byte 0 sits in [31:24].
    always_comb begin
        w_accept    = req_valid && req_ready;
        w_last      = byte_count(load_mode) - 3'd1;
        w_ack       = (bus_re || bus_we) && bus_ack;
        w_assembled = {r_rsh, bus_rdata};
        if (mem_read == mem_write) begin
            w_err = 1'b1;
        end else if (load_mode == LD_ILLEGAL) begin
            w_err = 1'b1;
        end else if (load_mode == LD_WORD) begin
            w_err = (address[1:0] != 2'b00);
        end else begin
            w_err = address[0];
        end
        if (load_mode == LD_WORD) begin
            w_st_data = write_data;
        end else begin
            w_st_data = {write_data[15:0], 16'h0000};
        end
    end

    mem_lsu_extend u_extend (
        .i_assembled (w_assembled),
        .i_mode      (r_mode),
        .o_data      (w_ext)
    );

    // Transfer FSM; every output is registered so strobes drop on reset at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= LD_WORD;
            r_is_load  <= 1'b0;
            r_k        <= 3'd0;
            r_last     <= 3'd0;
            r_tmo      <= '0;
            r_wsh      <= 32'h0000_0000;
            r_rsh      <= 24'h00_0000;
            req_ready  <= 1'b1;
            bus_addr   <= 32'h0000_0000;
            bus_re     <= 1'b0;
            bus_we     <= 1'b0;
            bus_wdata  <= 8'h00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            read_data  <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        r_mode    <= load_mode;
                        r_is_load <= mem_read;
                        r_last    <= w_last;
                        r_k       <= 3'd0;
                        r_tmo     <= '0;
                        r_rsh     <= 24'h00_0000;
                        if (w_err) begin
                            r_state    <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            r_state   <= S_XFER;
                            bus_re    <= mem_read;
                            bus_we    <= mem_write;
                            bus_addr  <= address;
                            bus_wdata <= w_st_data[31:24];
                            r_wsh     <= {w_st_data[23:0], 8'h00};
                        end
                    end
                end
                S_XFER: begin
                    if (w_ack) begin
                        r_tmo <= '0;
                        if (r_is_load) begin
                            r_rsh <= w_assembled[23:0];
                        end else begin
                            r_rsh <= r_rsh;
                        end
                        if (r_k == r_last) begin
                            r_state    <= S_DONE;
                            bus_re     <= 1'b0;
                            bus_we     <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            if (r_is_load) begin
                                read_data <= w_ext;
                            end else begin
                                read_data <= read_data;
                            end
                        end else begin
                            r_k       <= r_k + 3'd1;
                            bus_addr  <= bus_addr + 32'd1;
                            bus_wdata <= r_wsh[31:24];
                            r_wsh     <= {r_wsh[23:0], 8'h00};
                        end
                    end else if (r_tmo == TMO_LIMIT) begin
                        // Abort: bytes already stored are deliberately not undone.
                        r_state    <= S_DONE;
                        bus_re     <= 1'b0;
                        bus_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    bus_re     <= 1'b0;
                    bus_we     <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Directed bench for mem_load_store_unit: byte-memory responder with
// programmable ack delay and a queue of expected bus transfers.
module tb_mem_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  load_mode = 2'b00;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] bus_addr;
    logic        bus_re;
    logic        bus_we;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] read_data;
    logic        stall;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [7:0]  mem [0:1023];
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    int          wcnt;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_load_store_unit #(.ACK_TIMEOUT(16), .TMO_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .load_mode  (load_mode),
        .address    (address),
        .write_data (write_data),
        .bus_addr   (bus_addr),
        .bus_re     (bus_re),
        .bus_we     (bus_we),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .read_data  (read_data),
        .stall      (stall)
    );

    assign bus_ack   = (bus_re || bus_we) && ack_en && (wcnt >= ack_delay);
    assign bus_rdata = mem[bus_addr[9:0]];

    // Memory responder: counts wait cycles per byte and commits store bytes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else begin
            if ((bus_re || bus_we) && !bus_ack) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (bus_we && bus_ack) mem[bus_addr[9:0]] <= bus_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request: push expected transfers, drive, watch the bus, check response.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [1:0] mode, input logic [31:0] addr,
                          input logic [31:0] wd, input logic push,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat, input int exp_strobes);
        int    n;
        int    strobes;
        int    lat;
        xfer_t x;
        n = (mode == 2'b00) ? 4 : 2;
        if (push) begin
            for (int k = 0; k < n; k++) begin
                x.addr = addr + 32'(k);
                x.we   = wr;
                x.data = wd[8*(n-1-k) +: 8];
                exp_q.push_back(x);
            end
        end
        @(negedge clk);
        chk({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr;
        load_mode = mode; address = addr; write_data = wd;
        #1 chk({tag, ":stall_acc"}, {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        strobes = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc;
                break;
            end
            chk({tag, ":stall"}, {31'd0, stall}, 32'd1);
            if (bus_re || bus_we) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    chk({tag, ":spurious_strobe"}, bus_addr, 32'hFFFF_FFFF);
                end else begin
                    x = exp_q[0];
                    chk({tag, ":addr"}, bus_addr, x.addr);
                    chk({tag, ":dir"}, {30'd0, bus_we, bus_re}, {30'd0, x.we, !x.we});
                    if (x.we) chk({tag, ":wdata"}, {24'd0, bus_wdata}, {24'd0, x.data});
                    if (bus_ack) void'(exp_q.pop_front());
                end
            end
        end
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":strobes"}, 32'(strobes), 32'(exp_strobes));
        chk({tag, ":err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, ":rdata"}, read_data, exp_rd);
        @(negedge clk);
        chk({tag, ":pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ":ready_after"}, {31'd0, req_ready}, 32'd1);
        if (!exp_err) chk({tag, ":q_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h12; mem[10'h101] = 8'h34;
        mem[10'h102] = 8'h56; mem[10'h103] = 8'h78;
        mem[10'h202] = 8'h80; mem[10'h203] = 8'h01;

        #12;
        chk("rst:ready", {31'd0, req_ready}, 32'd1);
        chk("rst:strobes", {30'd0, bus_re, bus_we}, 32'd0);
        chk("rst:resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst:rdata", read_data, 32'd0);
        chk("rst:stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        ack_delay = 0;
        do_req("ldw", 1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 5, 4);
        do_req("ldhs", 1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001, 3, 2);
        do_req("ldhu", 1'b1, 1'b0, 2'b10, 32'h202, 32'h0, 1'b1, 1'b0, 32'h0000_8001, 3, 2);

        ack_delay = 3;
        do_req("stw", 1'b0, 1'b1, 2'b00, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_8001, 17, 16);
        chk("stw:mem", {mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43]}, 32'hDEAD_BEEF);

        ack_delay = 0;
        do_req("misal", 1'b1, 1'b0, 2'b00, 32'h101, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1, 0);
        do_req("mode11", 1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1, 0);
        do_req("rdwr", 1'b1, 1'b1, 2'b00, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1, 0);
        do_req("noop", 1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1, 0);
        do_req("misalh", 1'b1, 1'b0, 2'b10, 32'h203, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 1, 0);

        do_req("sth", 1'b0, 1'b1, 2'b01, 32'h50, 32'h1234_ABCD, 1'b1, 1'b0, 32'h0000_8001, 3, 2);
        chk("sth:mem", {16'd0, mem[10'h50], mem[10'h51]}, 32'h0000_ABCD);

        ack_en = 1'b0;
        do_req("tmo", 1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0000_8001, 17, 16);
        ack_en = 1'b1;
        do_req("after_tmo", 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0000_1234, 3, 2);

        // Reset while the third byte of a slow store is on the bus.
        ack_delay = 3;
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        load_mode = 2'b00; address = 32'h60; write_data = 32'h1122_3344;
        @(posedge clk);
        #1 req_valid = 1'b0; mem_write = 1'b0;
        begin
            int found = 0;
            for (int cyc = 0; cyc < 50; cyc++) begin
                @(negedge clk);
                if (bus_we && bus_addr == 32'h62) begin
                    found = 1;
                    break;
                end
            end
            chk("rstmid:reach_byte2", 32'(found), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid:strobes", {30'd0, bus_re, bus_we}, 32'd0);
        chk("rstmid:ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid:mem", {mem[10'h60], mem[10'h61], mem[10'h62]}, 32'h0011_2200);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid:ready_rel", {31'd0, req_ready}, 32'd1);
        chk("rstmid:rdata", read_data, 32'd0);
        ack_delay = 1;
        do_req("post_rst", 1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 9, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
